// File: rtl/supercar_if.sv
// Handshake and LED-bar bundle between a scan controller and its requester.
// The master side issues start/stop/tick; the slave side is the controller.
interface supercar_if #(
  parameter int N_LED = 8
) ();
  localparam int PW = $clog2(N_LED);

  logic             start;
  logic             stop;
  logic             tick;
  logic             pres_en;
  logic             pres_clr;
  logic [N_LED-1:0] led;
  logic [PW-1:0]    pos;
  logic             dir;
  logic             busy;
  logic             bounce;
  logic             done;

  modport master (
    output start, stop, tick,
    input  pres_en, pres_clr, led, pos, dir, busy, bounce, done
  );

  modport slave (
    input  start, stop, tick,
    output pres_en, pres_clr, led, pos, dir, busy, bounce, done
  );
endinterface

// File: rtl/supercar_ctrl.sv
// Back-and-forth LED scanner: one lit LED sweeps the bar, advancing one position
// every DWELL prescaler ticks, optionally stopping after BOUNCES round trips.
module supercar_ctrl #(
  parameter int N_LED   = 8,
  parameter int DWELL   = 1,
  parameter int BOUNCES = 0
) (
  input  logic      clk,
  input  logic      rst,
  supercar_if.slave bus
);
  localparam int PW = $clog2(N_LED);
  localparam int DW = $clog2(DWELL + 1);
  localparam int SW = (BOUNCES > 0) ? $clog2(BOUNCES + 1) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q,    state_d;
  logic [PW-1:0]    pos_q,      pos_d;
  logic             dir_q,      dir_d;
  logic [DW-1:0]    dwell_q,    dwell_d;
  logic [SW-1:0]    sweep_q,    sweep_d;
  logic [N_LED-1:0] led_q,      led_d;
  logic             busy_q,     busy_d;
  logic             pres_en_q,  pres_en_d;
  logic             pres_clr_q, pres_clr_d;
  logic             bounce_q,   bounce_d;
  logic             done_q,     done_d;

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    dwell_d    = dwell_q;
    sweep_d    = sweep_q;
    pres_clr_d = 1'b0;
    bounce_d   = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d    = S_RUN;
          pos_d      = '0;
          dir_d      = 1'b0;
          dwell_d    = '0;
          sweep_d    = '0;
          pres_clr_d = 1'b1;
        end
      end
      default: begin
        if (bus.stop) begin
          state_d = S_IDLE;
          pos_d   = '0;
          dir_d   = 1'b0;
        end else if (bus.tick) begin
          if (dwell_q == DW'(DWELL - 1)) begin
            dwell_d = '0;
            if (!dir_q) begin
              pos_d = pos_q + PW'(1);
              if (pos_d == PW'(N_LED - 1)) begin
                dir_d    = 1'b1;
                bounce_d = 1'b1;
              end
            end else begin
              pos_d = pos_q - PW'(1);
              if (pos_d == '0) begin
                dir_d    = 1'b0;
                bounce_d = 1'b1;
                sweep_d  = sweep_q + SW'(1);
                // Round trip complete at LED 0; pos/dir are already at rest values.
                if (BOUNCES != 0 && sweep_d == SW'(BOUNCES)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end
              end
            end
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
      end
    endcase

    busy_d    = (state_d == S_RUN);
    pres_en_d = busy_d;
    led_d     = busy_d ? (N_LED'(1) << pos_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      dwell_q    <= '0;
      sweep_q    <= '0;
      led_q      <= '0;
      busy_q     <= 1'b0;
      pres_en_q  <= 1'b0;
      pres_clr_q <= 1'b0;
      bounce_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      dwell_q    <= dwell_d;
      sweep_q    <= sweep_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      pres_en_q  <= pres_en_d;
      pres_clr_q <= pres_clr_d;
      bounce_q   <= bounce_d;
      done_q     <= done_d;
    end
  end

  assign bus.pos      = pos_q;
  assign bus.dir      = dir_q;
  assign bus.led      = led_q;
  assign bus.busy     = busy_q;
  assign bus.pres_en  = pres_en_q;
  assign bus.pres_clr = pres_clr_q;
  assign bus.bounce   = bounce_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_supercar_ctrl.sv
// Three scanner configurations driven by shared stimulus and compared every
// cycle against a triangle-wave model derived from elapsed tick counts.
module tb_supercar_ctrl;
  localparam int NA = 4, DA = 2, BA = 1;
  localparam int NB = 2, DB = 1, BB = 0;
  localparam int NC = 5, DC = 3, BC = 2;

  logic clk;
  logic rst;
  logic start_i, stop_i, tick_i;

  int total;
  int bad;

  int cfg_n [3] = '{NA, NB, NC};
  int cfg_d [3] = '{DA, DB, DC};
  int cfg_b [3] = '{BA, BB, BC};

  typedef struct {
    bit run;
    int ticks;
    bit clr;
    bit bounce;
    bit done;
  } mdl_t;
  mdl_t m [3];

  supercar_if #(.N_LED(NA)) if_a ();
  supercar_if #(.N_LED(NB)) if_b ();
  supercar_if #(.N_LED(NC)) if_c ();

  assign if_a.start = start_i;  assign if_a.stop = stop_i;  assign if_a.tick = tick_i;
  assign if_b.start = start_i;  assign if_b.stop = stop_i;  assign if_b.tick = tick_i;
  assign if_c.start = start_i;  assign if_c.stop = stop_i;  assign if_c.tick = tick_i;

  supercar_ctrl #(.N_LED(NA), .DWELL(DA), .BOUNCES(BA)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  supercar_ctrl #(.N_LED(NB), .DWELL(DB), .BOUNCES(BB)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  supercar_ctrl #(.N_LED(NC), .DWELL(DC), .BOUNCES(BC)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: the scanner position is a triangle wave of completed steps.
  function automatic void mdl_step(input int idx, input bit r, input bit s, input bit p, input bit t);
    int steps, period, phase;
    m[idx].clr    = 1'b0;
    m[idx].bounce = 1'b0;
    m[idx].done   = 1'b0;
    if (r) begin
      m[idx].run   = 1'b0;
      m[idx].ticks = 0;
    end else if (!m[idx].run) begin
      if (s && !p) begin
        m[idx].run   = 1'b1;
        m[idx].ticks = 0;
        m[idx].clr   = 1'b1;
      end
    end else if (p) begin
      m[idx].run = 1'b0;
    end else if (t) begin
      m[idx].ticks++;
      if (m[idx].ticks % cfg_d[idx] == 0) begin
        steps  = m[idx].ticks / cfg_d[idx];
        period = 2 * (cfg_n[idx] - 1);
        phase  = steps % period;
        if (phase == 0 || phase == cfg_n[idx] - 1) m[idx].bounce = 1'b1;
        if (phase == 0 && cfg_b[idx] != 0 && steps / period == cfg_b[idx]) begin
          m[idx].done = 1'b1;
          m[idx].run  = 1'b0;
        end
      end
    end
  endfunction

  task automatic chk_unit(input int idx, input logic [31:0] led, input logic [31:0] pos,
                          input logic dir, input logic busy, input logic pen, input logic pclr,
                          input logic bnc, input logic dn);
    int period, phase, epos, edir;
    logic [31:0] eled;
    epos = 0; edir = 0; eled = 32'd0;
    if (m[idx].run) begin
      period = 2 * (cfg_n[idx] - 1);
      phase  = (m[idx].ticks / cfg_d[idx]) % period;
      if (phase < cfg_n[idx] - 1) begin
        epos = phase;
        edir = 0;
      end else begin
        epos = period - phase;
        edir = 1;
      end
      eled = 32'd1 << epos;
    end
    chk($sformatf("u%0d.led", idx), led, eled);
    chk($sformatf("u%0d.pos", idx), pos, 32'(epos));
    chk($sformatf("u%0d.dir", idx), {31'd0, dir}, 32'(edir));
    chk($sformatf("u%0d.busy", idx), {31'd0, busy}, {31'd0, m[idx].run});
    chk($sformatf("u%0d.pres_en", idx), {31'd0, pen}, {31'd0, m[idx].run});
    chk($sformatf("u%0d.pres_clr", idx), {31'd0, pclr}, {31'd0, m[idx].clr});
    chk($sformatf("u%0d.bounce", idx), {31'd0, bnc}, {31'd0, m[idx].bounce});
    chk($sformatf("u%0d.done", idx), {31'd0, dn}, {31'd0, m[idx].done});
  endtask

  task automatic cyc(input bit r, input bit s, input bit p, input bit t);
    rst = r; start_i = s; stop_i = p; tick_i = t;
    @(posedge clk);
    for (int i = 0; i < 3; i++) mdl_step(i, r, s, p, t);
    @(negedge clk);
    chk_unit(0, 32'(if_a.led), 32'(if_a.pos), if_a.dir, if_a.busy, if_a.pres_en,
             if_a.pres_clr, if_a.bounce, if_a.done);
    chk_unit(1, 32'(if_b.led), 32'(if_b.pos), if_b.dir, if_b.busy, if_b.pres_en,
             if_b.pres_clr, if_b.bounce, if_b.done);
    chk_unit(2, 32'(if_c.led), 32'(if_c.pos), if_c.dir, if_c.busy, if_c.pres_en,
             if_c.pres_clr, if_c.bounce, if_c.done);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 3; i++) begin
      m[i].run = 1'b0; m[i].ticks = 0; m[i].clr = 1'b0; m[i].bounce = 1'b0; m[i].done = 1'b0;
    end
    rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; tick_i = 1'b0;

    $display("phase reset: 2 reset cycles, idle ticks");
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

    $display("phase start+stop together in idle");
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);

    $display("phase full run: start then 34 consecutive ticks");
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 34; i++) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);

    $display("phase stop with simultaneous tick at pos 2");
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);

    $display("phase start re-pulse mid-run, then reset mid-run");
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);

    $display("phase random: 3000 cycles");
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
